// File: rtl/grant_sequencer.sv
// rtl/grant_sequencer.sv - holds one-hot grants for a shared resource; optional ROUND_ROBIN_EN selects rotating priority
module grant_sequencer #(
  parameter int N        = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    pending,
  output logic            timeout,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t          state, state_next;
  logic [7:0]      hold_cnt;
  logic [N-1:0]    src;
  logic [N-1:0]    pick;
  logic [ID_W-1:0] pick_id;
  logic            done_hit;
  logic            expire;
  logic            clr_en;
  logic            start;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;
  logic [N-1:0]    above;

  // Candidates strictly above the last grantee, wrapping to all pending bits when none.
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(last_id)) above[i] = pending[i];
    end
    src = (|above) ? above : pending;
  end
`else
  // Fixed priority: every pending bit competes, lowest index wins.
  always_comb begin
    src = pending;
  end
`endif

  // Lowest set bit of the candidate set and its binary index.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) begin
        pick    = N'(1) << i;
        pick_id = ID_W'(i);
      end
    end
  end

  // Release conditions; done outranks the hold timeout.
  always_comb begin
    done_hit = (state == S_GRANT) && done;
    expire   = (state == S_GRANT) && !done && (hold_cnt == 8'(MAX_HOLD - 1));
    clr_en   = done_hit || expire;
    start    = (state == S_IDLE) && (|pending);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_GRANT;
      S_GRANT:   if (clr_en) state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    grant_valid = (state == S_GRANT);
    busy        = (state != S_IDLE);
  end

  // Pending accumulation, grant capture, hold counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      grant    <= '0;
      grant_id <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      // A request landing in its own clear cycle survives because req is ORed last.
      pending <= (pending & ~(clr_en ? grant : '0)) | req;
      timeout <= expire;
      if (start) begin
        grant    <= pick;
        grant_id <= pick_id;
        hold_cnt <= '0;
      end else if (clr_en) begin
        grant    <= '0;
        grant_id <= '0;
        hold_cnt <= '0;
      end else if (state == S_GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

`ifdef ROUND_ROBIN_EN
  // Remember the most recent grantee for the rotating search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_id <= ID_W'(N - 1);
    else if (start) last_id <= pick_id;
  end
`endif

endmodule

// File: tb/tb_grant_sequencer.sv
// tb/tb_grant_sequencer.sv - directed self-checking bench for grant_sequencer
module tb_grant_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] pending;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int failures = 0;

  grant_sequencer #(.N(8), .ID_W(3), .MAX_HOLD(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .pending(pending), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    step(); step();
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_id !== 3'd0 ||
        pending !== 8'h00 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state grant=%h valid=%b id=%0d pending=%h timeout=%b busy=%b expected all zero",
               grant, grant_valid, grant_id, pending, timeout, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_priority();
    req = 8'b00000110; step(); req = '0;
    checks++;
    if (pending !== 8'b00000110 || grant !== 8'h00) begin
      failures++;
      $display("FAIL basic_pending pending=%h grant=%h expected pending=06 grant=00", pending, grant);
    end
    step();
    checks++;
    if (grant !== 8'b00000010 || grant_id !== 3'd1 || grant_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_first_grant grant=%h id=%0d valid=%b busy=%b expected 02/1/1/1",
               grant, grant_id, grant_valid, busy);
    end
    done = 1'b1; step(); done = 1'b0;
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || busy !== 1'b1 || pending !== 8'b00000100 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL basic_release grant=%h valid=%b busy=%b pending=%h timeout=%b expected 00/0/1/04/0",
               grant, grant_valid, busy, pending, timeout);
    end
    step();
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_gap grant=%h busy=%b expected 00/0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 8'b00000100 || grant_id !== 3'd2 || grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_second_grant grant=%h id=%0d valid=%b expected 04/2/1", grant, grant_id, grant_valid);
    end
    done = 1'b1; step(); done = 1'b0;
    step(); step();
  endtask

  task automatic test_timeout();
    int held = 1;
    int pulses = 0;
    req = 8'b00100000; step(); req = '0; step();
    checks++;
    if (grant !== 8'b00100000 || grant_id !== 3'd5) begin
      failures++;
      $display("FAIL timeout_grant grant=%h id=%0d expected 20/5", grant, grant_id);
    end
    for (int n = 0; n < 30; n++) begin
      step();
      if (timeout === 1'b1) pulses++;
      if (grant === 8'b00100000) held++;
      else break;
    end
    step();
    if (timeout === 1'b1) pulses++;
    checks++;
    if (held !== 15) begin
      failures++;
      $display("FAIL timeout_hold_cycles got=%0d expected=15", held);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL timeout_pulse_count got=%0d expected=1", pulses);
    end
    checks++;
    if (pending[5] !== 1'b0 || grant !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_cleanup pending=%h grant=%h busy=%b expected pending[5]=0 grant=00 busy=0",
               pending, grant, busy);
    end
  endtask

  task automatic test_req_during_clear();
    req = 8'b00000010; step(); req = '0; step();
    checks++;
    if (grant !== 8'b00000010) begin
      failures++;
      $display("FAIL clear_race_grant grant=%h expected 02", grant);
    end
    done = 1'b1; req = 8'b00000010; step(); done = 1'b0; req = '0;
    checks++;
    if (pending[1] !== 1'b1 || grant !== 8'h00) begin
      failures++;
      $display("FAIL clear_race_pending pending=%h grant=%h expected pending[1]=1 grant=00", pending, grant);
    end
    step(); step();
    checks++;
    if (grant !== 8'b00000010 || grant_id !== 3'd1) begin
      failures++;
      $display("FAIL clear_race_regrant grant=%h id=%0d expected 02/1", grant, grant_id);
    end
    done = 1'b1; step(); done = 1'b0;
    step(); step();
  endtask

  task automatic test_idle_quiet();
    int bad = 0;
    req = '0;
    for (int n = 0; n < 20; n++) begin
      done = (n % 3 == 0);
      step();
      if (grant !== 8'h00 || grant_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) bad++;
    end
    done = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_quiet bad_cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_ids [5];
    exp_ids = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    req = 8'b01101110; step(); req = '0;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (grant_valid !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== exp_ids[k] || grant !== (8'h01 << exp_ids[k])) begin
        failures++;
        $display("FAIL order_%0d valid=%b id=%0d grant=%h expected id=%0d", k, grant_valid, grant_id, grant, exp_ids[k]);
      end
      step();
      done = 1'b1; step(); done = 1'b0;
    end
    step(); step();
    checks++;
    if (pending !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL order_drained pending=%h busy=%b expected 00/0", pending, busy);
    end
  endtask

  task automatic test_async_reset();
    req = 8'b00011000; step(); req = '0; step();
    checks++;
    if (grant !== 8'b00001000 || pending !== 8'b00011000) begin
      failures++;
      $display("FAIL arst_setup grant=%h pending=%h expected 08/18", grant, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h00 || pending !== 8'h00 || busy !== 1'b0 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate grant=%h pending=%h busy=%b valid=%b expected 00/00/0/0",
               grant, pending, busy, grant_valid);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_priority();
    test_timeout();
    test_req_during_clear();
    test_idle_quiet();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
